ifetch: RTL

Instruction fetch stage directly upstream of the decoder and directly downstream of the instruction ROM read port 1. It holds the program counter, reads one word per cycle from the asynchronous ROM, and queues the fetched word with its PC in a small FIFO. It presents instructions to decode over a valid/ready handshake and restarts at a new PC when a branch, jump or trap redirect arrives.

---
 rtl/ifetch.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch: PC, async ROM read, small {inst, pc, misaligned} FIFO to decode
// Optional misaligned-redirect trap marker enabled by IFETCH_MISALIGN_TRAP_EN.
module ifetch #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  rom_rd_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [31:0]           rom_rd_data,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst,
  output logic [31:0]           inst_pc,
  output logic                  inst_misaligned
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
  localparam logic RUN = 1'b0;

  logic [31:0]      pc_q;
  logic             state_q;
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [31:0]      inst_mem [BUF_DEPTH];
  logic [31:0]      pc_mem   [BUF_DEPTH];

  logic        push;
  logic        pop;
  logic        room;
  logic [31:0] push_inst;
  logic [31:0] redirect_target;
  logic        state_next;

  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid && inst_ready && !redirect;
  // A pop frees a slot in the same cycle, so a full FIFO still streams.
  assign room       = (count_q < DEPTH_C) || pop;
  assign rom_rd_en  = (state_q == RUN) && !redirect && room;
  assign rom_addr   = pc_q[ADDR_WIDTH+1:2];

  assign inst    = inst_valid ? inst_mem[rd_ptr_q] : 32'h0;
  assign inst_pc = inst_valid ? pc_mem[rd_ptr_q]   : 32'h0;

`ifdef IFETCH_MISALIGN_TRAP_EN
  localparam logic HALT = 1'b1;

  logic marker_q;
  logic push_marker;
  logic misaligned_target;
  logic mis_mem [BUF_DEPTH];

  assign misaligned_target = |redirect_pc[1:0];
  // In HALT the only push is the single trap marker carrying the faulting PC.
  assign push_marker     = (state_q == HALT) && marker_q && !redirect && room;
  assign push            = rom_rd_en || push_marker;
  assign push_inst       = push_marker ? 32'h0000_0013 : rom_rd_data;
  assign redirect_target = misaligned_target ? redirect_pc : {redirect_pc[31:2], 2'b00};
  assign state_next      = misaligned_target ? HALT : RUN;
  assign inst_misaligned = inst_valid ? mis_mem[rd_ptr_q] : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      marker_q <= 1'b0;
    end else if (redirect) begin
      marker_q <= misaligned_target;
    end else if (push_marker) begin
      marker_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mis_mem[wr_ptr_q] <= push_marker;
    end
  end
`else
  logic [1:0] unused_pc_lsb;

  assign unused_pc_lsb   = redirect_pc[1:0];
  assign push            = rom_rd_en;
  assign push_inst       = rom_rd_data;
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign state_next      = RUN;
  assign inst_misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= push_inst;
      pc_mem[wr_ptr_q]   <= pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_ADDR;
      state_q <= RUN;
    end else if (redirect) begin
      pc_q    <= redirect_target;
      state_q <= state_next;
    end else if (rom_rd_en) begin
      pc_q    <= pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else if (redirect) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
